// File: rtl/spi_ram_master_ctrl_pkg.sv
// Shared types and defaults for the SPI RAM master controller.
// Optional feature macro: SPI_CTRL_AUTO_READ_EN (see spi_ram_master_ctrl.sv).
package shared_pkg;

    localparam int MEM_WIDTH = 8;

    // Two-bit command carried at the top of every frame; bit 1 is the read/write command bit.
    typedef enum logic [1:0] {
        WRITE_ADD  = 2'b00,
        WRITE_DATA = 2'b01,
        READ_ADD   = 2'b10,
        READ_DATA  = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SHIFT_CMD = 3'd2,
        ST_WAIT_RD   = 3'd3,
        ST_SHIFT_RD  = 3'd4,
        ST_GAP       = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/spi_ram_master_ctrl_if.sv
// Host request/response bundle for the SPI RAM master controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the host keeps req_op/req_data stable while req_valid is high and unaccepted.
// rd_valid is a one-cycle pulse qualifying rd_data, with no back-pressure.
interface spi_ram_master_ctrl_if #(
    parameter int MEM_WIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [MEM_WIDTH-1:0] req_data;
    logic [MEM_WIDTH-1:0] rd_data;
    logic                 rd_valid;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rd_data, rd_valid
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_ram_master_ctrl_shift_reg.sv
// Frame shifter: parallel load, MSB-first shift out, serial shift in at the LSB,
// plus a per-phase cycle counter the controller clears on every state change.
module spi_shift_reg #(
    parameter int W  = 10,
    parameter int RW = 7,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          shift_en,
    input  logic          sin,
    input  logic          cnt_clr,
    output logic          sout,
    output logic [RW-1:0] rx_low,
    output logic [CW-1:0] cnt
);
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next shifter contents and phase counter; load wins over shift.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift_en) begin
            data_d = {data_q[W-2:0], sin};
        end
        cnt_d = cnt_clr ? '0 : cnt_q + 1'b1;
    end

    // Shifter and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sout   = data_q[W-1];
    assign rx_low = data_q[RW-1:0];
    assign cnt    = cnt_q;
endmodule

// File: rtl/spi_ram_master_ctrl.sv
// SPI RAM master controller: one host request becomes one SPI frame
// {op, data} shifted MSB first, with a read-back phase for READ_DATA.
// Optional macro SPI_CTRL_AUTO_READ_EN: a read request (op 10 or 11) issues a
// READ_ADD frame followed by a READ_DATA frame without returning to IDLE.
module spi_ram_master_ctrl #(
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH,
    parameter int RD_WAIT   = 1,
    parameter int IDLE_GAP  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_ram_master_ctrl_if.slave    host,
    output logic                    busy,
    output logic                    SS_n,
    output logic                    MOSI,
    input  logic                    MISO,
    output shared_pkg::ctrl_state_e state_dbg
);
    import shared_pkg::*;

    localparam int FW = MEM_WIDTH + 2;
    localparam int RW = MEM_WIDTH - 1;
    localparam int CW = $clog2(MEM_WIDTH + 10);

    ctrl_state_e          state_q, state_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [MEM_WIDTH-1:0] rd_data_q, rd_data_d;
`ifdef SPI_CTRL_AUTO_READ_EN
    logic                 auto_q, auto_d;
`endif

    logic                 sh_load;
    logic [FW-1:0]        sh_load_val;
    logic                 sh_shift_en;
    logic                 sh_sin;
    logic                 sh_cnt_clr;
    logic                 sh_sout;
    logic [RW-1:0]        sh_rx_low;
    logic [CW-1:0]        sh_cnt;

    spi_shift_reg #(.W(FW), .RW(RW), .CW(CW)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .load_val (sh_load_val),
        .shift_en (sh_shift_en),
        .sin      (sh_sin),
        .cnt_clr  (sh_cnt_clr),
        .sout     (sh_sout),
        .rx_low   (sh_rx_low),
        .cnt      (sh_cnt)
    );

    // Next state, frame latch, shifter control and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        sh_load = 1'b0;
`ifdef SPI_CTRL_AUTO_READ_EN
        auto_d  = auto_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    frame_d = {host.req_op, host.req_data};
`ifdef SPI_CTRL_AUTO_READ_EN
                    if (host.req_op[1]) begin
                        frame_d = {READ_ADD, host.req_data};
                        auto_d  = 1'b1;
                    end
`endif
                    sh_load = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_SHIFT_CMD;
            ST_SHIFT_CMD: begin
                if (int'(sh_cnt) == FW - 1) begin
                    if (frame_q[FW-1 -: 2] == READ_DATA) begin
                        state_d = (RD_WAIT == 0) ? ST_SHIFT_RD : ST_WAIT_RD;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (int'(sh_cnt) == RD_WAIT - 1) state_d = ST_SHIFT_RD;
            end
            ST_SHIFT_RD: begin
                if (int'(sh_cnt) == MEM_WIDTH - 1) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (int'(sh_cnt) == IDLE_GAP - 1) begin
                    state_d = ST_IDLE;
`ifdef SPI_CTRL_AUTO_READ_EN
                    // Second half of an automatic read: data-phase frame with zero payload.
                    if (auto_q) begin
                        frame_d = {READ_DATA, {MEM_WIDTH{1'b0}}};
                        sh_load = 1'b1;
                        auto_d  = 1'b0;
                        state_d = ST_START;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The shifter advances on the edge entering each command bit so MOSI can be registered.
        sh_load_val = frame_d;
        sh_shift_en = (state_d == ST_SHIFT_CMD) || (state_q == ST_SHIFT_RD);
        sh_sin      = (state_q == ST_SHIFT_RD) ? MISO : 1'b0;
        sh_cnt_clr  = (state_d != state_q);

        ss_n_d      = !(state_d inside {ST_START, ST_SHIFT_CMD, ST_WAIT_RD, ST_SHIFT_RD});
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
        mosi_d      = (state_d == ST_SHIFT_CMD) ? sh_sout : 1'b0;
        rd_valid_d  = (state_q == ST_SHIFT_RD) && (state_d == ST_GAP);
        rd_data_d   = rd_valid_d ? {sh_rx_low, MISO} : rd_data_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
`ifdef SPI_CTRL_AUTO_READ_EN
            auto_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
`ifdef SPI_CTRL_AUTO_READ_EN
            auto_q      <= auto_d;
`endif
        end
    end

    assign host.req_ready = req_ready_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign busy           = busy_q;
    assign SS_n           = ss_n_q;
    assign MOSI           = mosi_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Self-checking bench for spi_ram_master_ctrl: frame and read-data scoreboards
// fed by the request driver, checked by a negedge SPI monitor / slave model.
module tb_spi_ram_master_ctrl;
    import shared_pkg::*;

    localparam int MW   = 8;
    localparam int RDW  = 1;
    localparam int GAPC = 1;
    localparam int FW   = MW + 2;

    // ---------------- clock / reset ----------------
    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        busy;
    logic        ss_n;
    logic        mosi;
    logic        miso = 1'b0;
    ctrl_state_e state_dbg;

    always #5 clk = ~clk;

    spi_ram_master_ctrl_if #(.MEM_WIDTH(MW)) host_if ();

    spi_ram_master_ctrl #(.MEM_WIDTH(MW), .RD_WAIT(RDW), .IDLE_GAP(GAPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (host_if),
        .busy      (busy),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .MISO      (miso),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [FW-1:0]  exp_q[$];
    int             exp_len_q[$];
    logic [MW-1:0]  exp_rd_q[$];
    logic [MW-1:0]  slave_byte = '0;
    int             low_cnt = 0;
    int             hi_cnt  = 0;
    int             last_hi = 0;
    logic [FW-1:0]  cap = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int frame_len(input logic [1:0] op);
        // START + command bits, plus wait and data bits for a data read.
        if (op == 2'b11) return 1 + FW + RDW + MW;
        return 1 + FW;
    endfunction

    function automatic int ready_lat(input logic [1:0] op);
`ifdef SPI_CTRL_AUTO_READ_EN
        if (op[1]) return frame_len(2'b10) + GAPC + frame_len(2'b11) + GAPC + 1;
`endif
        return frame_len(op) + GAPC + 1;
    endfunction

    task automatic push_exp(input logic [1:0] op, input logic [MW-1:0] data);
`ifdef SPI_CTRL_AUTO_READ_EN
        if (op[1]) begin
            exp_q.push_back({2'b10, data});
            exp_len_q.push_back(frame_len(2'b10));
            exp_q.push_back({2'b11, {MW{1'b0}}});
            exp_len_q.push_back(frame_len(2'b11));
            exp_rd_q.push_back(slave_byte);
            return;
        end
`endif
        exp_q.push_back({op, data});
        exp_len_q.push_back(frame_len(op));
        if (op == 2'b11) exp_rd_q.push_back(slave_byte);
    endtask

    // SPI monitor and slave model: captures MOSI frames, drives MISO, checks rd_valid.
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
            miso    = 1'b0;
        end else begin
            if (!ss_n) begin
                if (low_cnt == 0) begin
                    last_hi = hi_cnt;
                    hi_cnt  = 0;
                end
                low_cnt++;
                if (low_cnt == 1) check_eq("start_mosi", {31'd0, mosi}, 32'd0);
                else if (low_cnt <= FW + 1) cap = {cap[FW-2:0], mosi};
                if (low_cnt >= FW + 2 + RDW && low_cnt <= FW + 1 + RDW + MW)
                    miso = slave_byte[FW + 1 + RDW + MW - low_cnt];
                else
                    miso = 1'b0;
            end else begin
                if (low_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("frame_spurious", 32'd1, 32'd0);
                    end else begin
                        check_eq("frame_bits", 32'(cap), 32'(exp_q.pop_front()));
                        check_eq("ss_low_len", low_cnt, exp_len_q.pop_front());
                    end
                end
                low_cnt = 0;
                miso    = 1'b0;
                hi_cnt++;
                check_eq("idle_mosi", {31'd0, mosi}, 32'd0);
            end
            if (host_if.rd_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check_eq("rd_spurious", 32'd1, 32'd0);
                end else begin
                    check_eq("rd_data", 32'(host_if.rd_data), 32'(exp_rd_q.pop_front()));
                    check_eq("rd_valid_ss_n", {31'd0, ss_n}, 32'd1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!host_if.req_ready && k < 500);
    endtask

    task automatic accept_req(input logic [1:0] op, input logic [MW-1:0] data);
        int k = 0;
        while (!host_if.req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check_eq("ready_timeout", 32'd0, 32'd1);
        host_if.req_valid = 1'b1;
        host_if.req_op    = op;
        host_if.req_data  = data;
        @(posedge clk);
        #1 host_if.req_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [MW-1:0] data);
        int k;
        push_exp(op, data);
        accept_req(op, data);
        wait_ready(k);
        check_eq("ready_lat", k, ready_lat(op));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [1:0]    op;
        logic [MW-1:0] d;
        host_if.req_valid = 1'b0;
        host_if.req_op    = 2'b00;
        host_if.req_data  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rd_valid", {31'd0, host_if.rd_valid}, 32'd0);
        check_eq("rst_rd_data", 32'(host_if.rd_data), 32'd0);
        check_eq("rst_req_ready", {31'd0, host_if.req_ready}, 32'd1);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write address A5: MOSI 0,0,1,0,1,0,0,1,0,1.
        send(2'b00, 8'hA5);
        send(2'b01, MW'($urandom_range(0, 255)));

        // Data read with slave returning 3C, then a write to confirm rd_data holds.
        slave_byte = 8'h3C;
        send(2'b11, MW'($urandom_range(0, 255)));
        send(2'b01, 8'h81);
        check_eq("rd_hold", 32'(host_if.rd_data), 32'h3C);
        check_eq("rd_hold_valid", {31'd0, host_if.rd_valid}, 32'd0);

`ifdef SPI_CTRL_AUTO_READ_EN
        slave_byte = 8'hFF;
        send(2'b10, 8'h10);
`else
        send(2'b10, 8'h10);
`endif

        // Back-to-back with req_valid held: second accepted when ready returns.
        push_exp(2'b00, 8'h11);
        push_exp(2'b01, 8'h22);
        wait_ready(k);
        host_if.req_valid = 1'b1;
        host_if.req_op    = 2'b00;
        host_if.req_data  = 8'h11;
        @(posedge clk);
        #1;
        host_if.req_op    = 2'b01;
        host_if.req_data  = 8'h22;
        wait_ready(k);
        check_eq("b2b_accept_lat", k, ready_lat(2'b00));
        @(posedge clk);
        #1 host_if.req_valid = 1'b0;
        wait_ready(k);
        // SS_n stays high for the GAP cycles plus the accepting IDLE cycle.
        check_eq("b2b_ss_gap", last_hi, GAPC + 1);

        // Request pulsed while busy must be ignored.
        push_exp(2'b01, 8'h5A);
        accept_req(2'b01, 8'h5A);
        repeat (3) @(negedge clk);
        check_eq("busy_mid", {31'd0, busy}, 32'd1);
        host_if.req_valid = 1'b1;
        host_if.req_op    = 2'b11;
        host_if.req_data  = 8'hFF;
        repeat (2) @(negedge clk);
        host_if.req_valid = 1'b0;
        wait_ready(k);
        repeat (4) @(negedge clk);

        // Reset in the middle of a data-read command phase.
        slave_byte = 8'hC3;
        accept_req(2'b11, 8'h44);
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_rst_ss_n", {31'd0, ss_n}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, host_if.req_ready}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_rd_valid", {31'd0, host_if.rd_valid}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        repeat (30) @(negedge clk);
        check_eq("mid_rst_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Random mix of operations.
        for (int i = 0; i < 8; i++) begin
            op         = 2'($urandom_range(0, 3));
            d          = MW'($urandom_range(0, 255));
            slave_byte = MW'($urandom_range(0, 255));
            send(op, d);
        end

        repeat (5) @(negedge clk);
        check_eq("frames_drained", exp_q.size(), 32'd0);
        check_eq("reads_drained", exp_rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
